// File: rtl/pcpi_mem_responder.sv
// Word-addressed local SRAM that answers single-outstanding coprocessor requests
// after WAIT_STATES extra cycles; define PCPI_MEM_ERR_EN for sticky out-of-range tracking.
module pcpi_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mem_valid,
    input  logic                           mem_write,
    input  logic [31:0]                    mem_addr,
    input  logic [31:0]                    mem_wdata,
    output logic                           mem_ready,
    output logic [31:0]                    mem_rdata,
    input  logic                           host_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] host_addr,
    input  logic [31:0]                    host_wdata,
    output logic                           err,
    output logic [31:0]                    err_addr,
    input  logic                           err_clr,
    output logic [1:0]                     state_dbg
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     cnt;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic           write_q;
    logic           accept;
    logic           enter_resp;
    logic [31:0]    acc_addr;
    logic [31:0]    acc_wdata;
    logic           acc_write;
    logic           acc_in_range;
    logic [AW-1:0]  acc_word;
    logic [31:0]    sram [DEPTH_WORDS];

    // Handshake: mem_valid is only sampled in IDLE while host_we is low; each accepted
    // request yields exactly one mem_ready pulse, and nothing is accepted until it has passed.
    assign accept = (state == S_IDLE) && mem_valid && !host_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state == S_RESP);
        state_dbg = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
        end else if (accept) begin
            cnt     <= 4'(WAIT_STATES);
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            write_q <= mem_write;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // With zero wait states the access happens on the accept edge itself, so use live inputs.
    assign acc_addr     = (state == S_IDLE) ? mem_addr  : addr_q;
    assign acc_wdata    = (state == S_IDLE) ? mem_wdata : wdata_q;
    assign acc_write    = (state == S_IDLE) ? mem_write : write_q;
    assign acc_in_range = (acc_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign acc_word     = acc_addr[AW+1:2];
    assign enter_resp   = (state_nxt == S_RESP) && !reset;

    // Coprocessor write is issued last so it wins a same-word collision with the host.
    always_ff @(posedge clk) begin
        if (host_we) begin
            sram[host_addr] <= host_wdata;
        end
        if (enter_resp && acc_write && acc_in_range) begin
            sram[acc_word] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= 32'd0;
        end else if (enter_resp && !acc_write && acc_in_range) begin
            mem_rdata <= sram[acc_word];
        end else begin
            mem_rdata <= 32'd0;
        end
    end

`ifdef PCPI_MEM_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= 32'd0;
        end else if (enter_resp && !acc_in_range) begin
            err <= 1'b1;
            if (!err) err_addr <= acc_addr;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_addr <= 32'd0;
        end
    end
`else
    logic unused_in;
    assign err       = 1'b0;
    assign err_addr  = 32'd0;
    assign unused_in = ^{err_clr, acc_addr[1:0]};
`endif

endmodule

// File: tb/tb_pcpi_mem_responder.sv
// Bench for pcpi_mem_responder: three instances (0, 3 and 5 wait states) sharing all
// inputs except mem_valid, checked by table vectors plus hand-written corner sequences.
module tb_pcpi_mem_responder;

    localparam int          AW      = 10;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;
`ifdef PCPI_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    mem_valid_v;
    logic          mem_write;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic          err_clr;
    logic          ready_v    [3];
    logic [31:0]   rdata_v    [3];
    logic          err_v      [3];
    logic [31:0]   err_addr_v [3];
    logic [1:0]    state_v    [3];

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          k1;
    int          k2;
    int          npulse;
    logic        any_ready;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pcpi_mem_responder #(
            .DEPTH_WORDS (1024),
            .BASE_ADDR   (32'h0001_0000),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .mem_valid  (mem_valid_v[g]),
            .mem_write  (mem_write),
            .mem_addr   (mem_addr),
            .mem_wdata  (mem_wdata),
            .mem_ready  (ready_v[g]),
            .mem_rdata  (rdata_v[g]),
            .host_we    (host_we),
            .host_addr  (host_addr),
            .host_wdata (host_wdata),
            .err        (err_v[g]),
            .err_addr   (err_addr_v[g]),
            .err_clr    (err_clr),
            .state_dbg  (state_v[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic host_wr(input logic [AW-1:0] a, input logic [31:0] v);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = v;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic err_clear();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err after clr", 32'(err_v[0]), 32'h0);
        check("err_addr after clr", err_addr_v[0], 32'h0);
    endtask

    // One request; optional host write (hh) landing on the same edge that enters RESP.
    task automatic txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input bit hh, input logic [AW-1:0] ha,
                       input logic [31:0] hd);
        int          k;
        bit          seen;
        logic [31:0] e;
        @(negedge clk);
        mem_valid_v[d] = 1'b1; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        exp_q.push_back(exp);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (ready_v[d]) begin
                seen = 1'b1;
                check($sformatf("latency d%0d", d), k, ws_of(d) + 1);
                e = exp_q.pop_front();
                check($sformatf("rdata d%0d addr %08h", d, addr), rdata_v[d], e);
            end else begin
                check($sformatf("rdata before ready d%0d", d), rdata_v[d], 32'h0);
            end
            if (k == 1) begin
                mem_valid_v[d] = 1'b0;
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_write = 1'($urandom_range(0, 1));
            end
            if (hh && k == ws_of(d)) begin
                host_we = 1'b1; host_addr = ha; host_wdata = hd;
            end
            if (hh && k == ws_of(d) + 1) host_we = 1'b0;
        end
        host_we = 1'b0;
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout d%0d addr %08h: no mem_ready in 40 cycles, expected one", d, addr);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
        check($sformatf("ready after resp d%0d", d), 32'(ready_v[d]), 32'h0);
        check($sformatf("rdata after resp d%0d", d), rdata_v[d], 32'h0);
        check($sformatf("state after resp d%0d", d), 32'(state_v[d]), 32'(ST_IDLE));
    endtask

    // ---------------- test ----------------
    initial begin
        reset = 1'b1;
        mem_valid_v = 3'b000; mem_write = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        host_we = 1'b0; host_addr = '0; host_wdata = 32'h0; err_clr = 1'b0;

        vecs.push_back('{0, 1'b0, 32'h0001_0014, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b1, 32'h0001_0000, 32'hA5A5_0001, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0001_0000, 32'h0,         32'hA5A5_0001});
        vecs.push_back('{0, 1'b1, 32'h0001_0FFC, 32'h1111_2222, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0001_0FFF, 32'h0,         32'h1111_2222});
        vecs.push_back('{0, 1'b1, 32'h0001_1000, 32'hBAD0_BAD0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0001_1000, 32'h0,         32'h0});
        vecs.push_back('{0, 1'b0, 32'h0001_0000, 32'h0,         32'hA5A5_0001});
        vecs.push_back('{0, 1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0001_0FFC, 32'h0,         32'h1111_2222});
        vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0});
        vecs.push_back('{0, 1'b1, 32'h0001_0016, 32'h0BAD_CAFE, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0001_0014, 32'h0,         32'h0BAD_CAFE});
        vecs.push_back('{1, 1'b1, 32'h0001_0000, 32'h1234_5678, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0001_0000, 32'h0,         32'h1234_5678});
        vecs.push_back('{2, 1'b0, 32'h0001_0014, 32'h0,         32'hDEAD_BEEF});

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset ready d%0d", d), 32'(ready_v[d]), 32'h0);
            check($sformatf("reset rdata d%0d", d), rdata_v[d], 32'h0);
            check($sformatf("reset err d%0d", d), 32'(err_v[d]), 32'h0);
            check($sformatf("reset err_addr d%0d", d), err_addr_v[d], 32'h0);
            check($sformatf("reset state d%0d", d), 32'(state_v[d]), 32'(ST_IDLE));
        end
        reset = 1'b0;

        host_wr(10'd5, 32'hDEAD_BEEF);
        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp, 1'b0, '0, 32'h0);
        end

        // sticky error: first out-of-range access of the table was the write to 0x00011000
        check("err after table", 32'(err_v[0]), ERR_EN ? 32'h1 : 32'h0);
        check("err_addr after table", err_addr_v[0], ERR_EN ? 32'h0001_1000 : 32'h0);
        err_clear();
        txn(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, '0, 32'h0);
        txn(0, 1'b1, 32'h0002_0000, 32'h5555_AAAA, 32'h0, 1'b0, '0, 32'h0);
        check("err after oor pair", 32'(err_v[0]), ERR_EN ? 32'h1 : 32'h0);
        check("err_addr after oor pair", err_addr_v[0], 32'h0);
        err_clear();

        // host_we held with mem_valid: no accept until host_we drops
        @(negedge clk);
        host_we = 1'b1; host_addr = 10'd7; host_wdata = 32'h7777_7777;
        mem_valid_v[0] = 1'b1; mem_write = 1'b0; mem_addr = 32'h0001_001C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready while host_we", 32'(ready_v[0]), 32'h0);
            check("state while host_we", 32'(state_v[0]), 32'(ST_IDLE));
        end
        host_we = 1'b0;
        exp_q.push_back(32'h7777_7777);
        @(negedge clk);
        check("ready after host_we falls", 32'(ready_v[0]), 32'h1);
        check("rdata after host_we falls", rdata_v[0], exp_q.pop_front());
        mem_valid_v[0] = 1'b0;
        @(negedge clk);
        check("ready one cycle only", 32'(ready_v[0]), 32'h0);

        // same-edge host/coprocessor write to one word: coprocessor data stays
        txn(1, 1'b1, 32'h0001_0028, 32'hC0C0_C0C0, 32'h0, 1'b1, 10'd10, 32'h0F0F_0F0F);
        txn(1, 1'b0, 32'h0001_0028, 32'h0, 32'hC0C0_C0C0, 1'b0, '0, 32'h0);

        // read sees data from before a same-edge host write
        host_wr(10'd11, 32'h1111_BBBB);
        txn(1, 1'b0, 32'h0001_002C, 32'h0, 32'h1111_BBBB, 1'b1, 10'd11, 32'h2222_CCCC);
        txn(1, 1'b0, 32'h0001_002C, 32'h0, 32'h2222_CCCC, 1'b0, '0, 32'h0);

        // mem_valid held high: responses separated by one idle cycle
        @(negedge clk);
        mem_valid_v[1] = 1'b1; mem_write = 1'b0; mem_addr = 32'h0001_0000;
        k1 = -1; k2 = -1; npulse = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (ready_v[1]) begin
                check("b2b rdata", rdata_v[1], 32'h1234_5678);
                if (npulse == 0) k1 = k; else k2 = k;
                npulse++;
            end
            if (k == 5) check("b2b idle gap state", 32'(state_v[1]), 32'(ST_IDLE));
            if (k == 9) mem_valid_v[1] = 1'b0;
        end
        check("b2b first latency", k1, 32'd4);
        check("b2b second latency", k2, 32'd9);
        check("b2b pulse count", npulse, 32'd2);

        // reset in the middle of a 5-wait-state write
        host_wr(10'd20, 32'h2020_2020);
        @(negedge clk);
        mem_valid_v[2] = 1'b1; mem_write = 1'b1; mem_addr = 32'h0001_0050; mem_wdata = 32'hDEAD_0020;
        @(negedge clk);
        mem_valid_v[2] = 1'b0;
        @(negedge clk);
        check("state before reset", 32'(state_v[2]), 32'(ST_WAIT));
        reset = 1'b1;
        #1;
        check("state in reset", 32'(state_v[2]), 32'(ST_IDLE));
        check("ready in reset", 32'(ready_v[2]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        any_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            any_ready = any_ready | ready_v[2];
        end
        check("no ready after abort", 32'(any_ready), 32'h0);
        txn(2, 1'b0, 32'h0001_0050, 32'h0, 32'h2020_2020, 1'b0, '0, 32'h0);
        txn(0, 1'b0, 32'h0001_0014, 32'h0, 32'h0BAD_CAFE, 1'b0, '0, 32'h0);

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
